dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data memory `dmem` between the CPU load/store port and one DMA requester. It issues at most one access to `dmem` per cycle and stalls the CPU whenever the DMA port holds the memory. Arbitration is round-robin, with a bounded DMA burst lock. The block sits between the datapath's data-memory port and `dmem`, and is transparent to the CPU when the DMA port is idle.

## Interface
- `MAX_BURST`, default 8: maximum number of consecutive locked DMA grants; legal range 1..255.
- `DEPTH`, default 64: number of `dmem` words; word index `a[31:2]` >= DEPTH is out of range.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `c_req`  in  1  CPU requests a data access this cycle.
- `c_we`  in  1  CPU access is a write.
- `c_a`  in  32  CPU byte address; word-aligned.
- `c_wd`  in  32  CPU write data.
- `c_rd`  out  32  CPU read data.
- `c_stall`  out  1  CPU must hold its access and the PC.
- `d_req`  in  1  DMA requests an access.
- `d_we`  in  1  DMA access is a write.
- `d_a`  in  32  DMA byte address.
- `d_wd`  in  32  DMA write data.
- `d_lock`  in  1  DMA asks to keep the grant for the next cycle (burst).
- `d_rd`  out  32  DMA read data.
- `d_ack`  out  1  DMA access performed this cycle.
- `m_we`  out  1  to `dmem` `we`.
- `m_a`  out  32  to `dmem` `a`.
- `m_wd`  out  32  to `dmem` `wd`.
- `m_rd`  in  32  from `dmem` `rd` (combinational read).
- `err`  out  1  one-cycle pulse: the granted access was out of range.

## Operation
- Registered state:
  - `last`: 0 = CPU granted last, 1 = DMA granted last.
  - FSM `{RR, LOCK}`.
  - `bcnt`: burst counter, width clog2(MAX_BURST+1).
- Grant is combinational from the requests and the registered state. `gc` is the CPU grant and `gd` is the DMA grant; they are mutually exclusive.
  - RR state: only one requester active, that requester is granted. Both active: grant CPU if `last`=1, otherwise grant DMA. Neither active: no grant.
  - LOCK state: if `d_req`=1 and `bcnt` < MAX_BURST, grant DMA. Otherwise grant CPU if `c_req`=1, else grant DMA if `d_req`=1.
- Outputs:
  - `c_stall` = `c_req` & !`gc`.
  - `d_ack` = `gd`.
- Memory mux: `m_a`/`m_wd` come from the granted port, and from the CPU port when nothing is granted. `m_we` = granted port's `we` & in-range; it is 0 when nothing is granted.
- Read data: `c_rd` = `m_rd` and `d_rd` = `m_rd` when that port is in range, else 0x00000000. `c_rd` and `d_rd` are valid only in that port's grant cycle.
- Out of range: a granted access with `a[31:2]` >= DEPTH performs no write, returns 0, pulses `err`, and still completes (stall released / ack given).
- Transitions on the clock edge:
  - `gc`: `last`<=0, FSM<=RR, `bcnt`<=0.
  - `gd` & `d_lock`: `last`<=1, FSM<=LOCK, `bcnt`<=`bcnt`+1, saturating at MAX_BURST.
  - `gd` & !`d_lock`: `last`<=1, FSM<=RR, `bcnt`<=0.
  - No grant: FSM<=RR, `bcnt`<=0, `last` unchanged.
- Starvation bound: once `bcnt` = MAX_BURST, a pending CPU request wins the next cycle regardless of `d_lock`.
- Simultaneous write requests: only the granted one reaches `dmem`. The loser's data is ignored and must be held by its requester.

## Timing
- Zero-latency path from requests to grant, `c_stall`, `d_ack`, and `m_*`. Read data is valid in the same cycle as the grant.
- A stalled CPU holds `c_a`/`c_we`/`c_wd` until `c_stall`=0. DMA holds its request until `d_ack`=1.
- A write commits at the rising edge that ends the grant cycle.
- Reset, applied at any cycle including mid-burst: FSM<=RR, `last`<=1, `bcnt`<=0.
  - While `reset`=1, all grants are forced off: `c_stall`=0, `d_ack`=0, `m_we`=0, `err`=0.
  - `c_rd`/`d_rd`/`m_a`/`m_wd` follow the CPU port.
- After `reset` deasserts, the first simultaneous request goes to the CPU.
- Worst-case CPU wait is MAX_BURST cycles.

## Test plan
- After reset, `c_req`=`d_req`=1, both reads, held 4 cycles -> grants alternate C,D,C,D. `c_stall` pattern is 0,1,0,1 and `d_ack` pattern is 0,1,0,1.
- DMA write 0xDEADBEEF to 0x10 with CPU idle -> `d_ack`=1 and `m_we`=1 in the same cycle. A later CPU read of 0x10 returns 0xDEADBEEF with `c_stall`=0.
- DMA holds `d_lock`=1 with `c_req`=1 and MAX_BURST=8 -> exactly 8 consecutive `d_ack` cycles while `c_stall`=1. Cycle 9 grants the CPU with `c_stall`=0.
- CPU write to 0x100 (word 64) with DEPTH=64 -> `m_we`=0, `err` pulses for 1 cycle, `c_stall`=0, and memory is unchanged.
- Assert `reset` during the 3rd cycle of a locked burst with `c_req`=1 -> `d_ack`=0 and `m_we`=0 while in reset. On release, both requesting gives the CPU the grant first.
- Simultaneous writes (CPU 0x11111111 to 0x20, DMA 0x22222222 to 0x20, `last`=1) -> CPU write commits first and the DMA write commits the next cycle. The final read returns 0x22222222.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin data-memory arbiter between CPU and DMA with bounded DMA burst lock
module dmem_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_a,
    input  logic [31:0] c_wd,
    output logic [31:0] c_rd,
    output logic        c_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_a,
    input  logic [31:0] d_wd,
    input  logic        d_lock,
    output logic [31:0] d_rd,
    output logic        d_ack,
    output logic        m_we,
    output logic [31:0] m_a,
    output logic [31:0] m_wd,
    input  logic [31:0] m_rd,
    output logic        err
);

    localparam int              BW      = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   MAX_W   = BW'(MAX_BURST);
    localparam logic [29:0]     DEPTH_W = 30'(DEPTH);

    typedef enum logic {RR, LOCK} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          gc, gd;
    logic          c_in, d_in;

    assign c_in = c_a[31:2] < DEPTH_W;
    assign d_in = d_a[31:2] < DEPTH_W;

    // Reset suppresses every grant so nothing reaches dmem mid-reset.
    always_comb begin
        gc = 1'b0;
        gd = 1'b0;
        if (!reset) begin
            if (state_q == LOCK && d_req && bcnt_q < MAX_W) begin
                gd = 1'b1;
            end else if (state_q == LOCK) begin
                gc = c_req;
                gd = !c_req && d_req;
            end else if (c_req && d_req) begin
                gc = last_q;
                gd = !last_q;
            end else begin
                gc = c_req;
                gd = d_req;
            end
        end
    end

    assign c_stall = c_req && !gc && !reset;
    assign d_ack   = gd;
    assign m_a     = gd ? d_a  : c_a;
    assign m_wd    = gd ? d_wd : c_wd;
    assign m_we    = (gc && c_we && c_in) || (gd && d_we && d_in);
    assign err     = (gc && !c_in) || (gd && !d_in);
    assign c_rd    = c_in ? m_rd : 32'h0000_0000;
    assign d_rd    = d_in ? m_rd : 32'h0000_0000;

    always_comb begin
        state_d = RR;
        bcnt_d  = '0;
        last_d  = last_q;
        if (gc) begin
            last_d = 1'b0;
        end else if (gd) begin
            last_d = 1'b1;
            if (d_lock) begin
                state_d = LOCK;
                bcnt_d  = (bcnt_q == MAX_W) ? MAX_W : bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RR;
            last_q  <= 1'b1;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule
